// File: rtl/vga_plot_arbiter_if.sv
// Purpose : bundles the VGA pixel-write port shared between the drawing engines
//           (screen clear, row draw, correct-tile recolour, fail-line colour)
//           and the arbiter that owns the single adapter write port.
// Signals : req/done/plot_in   per-requester request, release pulse, pixel strobe
//           x_in/y_in/colour_in packed per-requester pixel payloads
//           gnt/busy            one-hot grant and ownership flag
//           vga_*               registered pixel write towards the VGA adapter
//           timeout_err         sticky watchdog flag
// Modports: master = engine side (drives requests), slave = arbiter side.
interface vga_plot_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned X_W     = 8,
    parameter int unsigned Y_W     = 7,
    parameter int unsigned COLOR_W = 3
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ-1:0]         done;
    logic [NUM_REQ-1:0]         plot_in;
    logic [NUM_REQ*X_W-1:0]     x_in;
    logic [NUM_REQ*Y_W-1:0]     y_in;
    logic [NUM_REQ*COLOR_W-1:0] colour_in;
    logic [NUM_REQ-1:0]         gnt;
    logic                       busy;
    logic [X_W-1:0]             vga_x;
    logic [Y_W-1:0]             vga_y;
    logic [COLOR_W-1:0]         vga_colour;
    logic                       vga_plot;
    logic                       timeout_err;

    modport master (
        output req, done, plot_in, x_in, y_in, colour_in,
        input  gnt, busy, vga_x, vga_y, vga_colour, vga_plot, timeout_err
    );

    modport slave (
        input  req, done, plot_in, x_in, y_in, colour_in,
        output gnt, busy, vga_x, vga_y, vga_colour, vga_plot, timeout_err
    );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Purpose : grants exclusive use of the VGA adapter pixel-write port to one
//           drawing engine at a time, forwards the owner's pixels with one cycle
//           of latency, and forces a release when an owner hangs.
// Ports   : clk    clock
//           reset  asynchronous, active-high reset
//           bus    vga_plot_arbiter_if.slave (requests in, grant + VGA write out)
// Config  : PLOT_ARB_ROUND_ROBIN_EN defined   -> round-robin from last owner + 1
//           PLOT_ARB_ROUND_ROBIN_EN undefined -> fixed priority, index 0 highest
module vga_plot_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned X_W     = 8,
    parameter int unsigned Y_W     = 7,
    parameter int unsigned COLOR_W = 3,
    parameter int unsigned TIMEOUT = 20000
) (
    input  logic              clk,
    input  logic              reset,
    vga_plot_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   owner_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               busy_q;
    logic [X_W-1:0]     vga_x_q;
    logic [Y_W-1:0]     vga_y_q;
    logic [COLOR_W-1:0] vga_colour_q;
    logic               vga_plot_q;
    logic               timeout_err_q;
    logic [WD_W-1:0]    wd_q;
`ifdef PLOT_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   last_q;
`endif

    // Unpack the per-requester payloads so the owner can be selected by index.
    logic [X_W-1:0]     x_arr      [NUM_REQ];
    logic [Y_W-1:0]     y_arr      [NUM_REQ];
    logic [COLOR_W-1:0] colour_arr [NUM_REQ];

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
        assign x_arr[g]      = bus.x_in[g*X_W +: X_W];
        assign y_arr[g]      = bus.y_in[g*Y_W +: Y_W];
        assign colour_arr[g] = bus.colour_in[g*COLOR_W +: COLOR_W];
    end

    // Winner selection for the next grant.
    logic [IDX_W-1:0] win_idx_c;
    logic             win_vld_c;

    always_comb begin
        win_idx_c = '0;
        win_vld_c = 1'b0;
`ifdef PLOT_ARB_ROUND_ROBIN_EN
        // Search starts one past the previous owner so every engine gets a turn.
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (!win_vld_c && bus.req[IDX_W'((int'(last_q) + 1 + k) % int'(NUM_REQ))]) begin
                win_vld_c = 1'b1;
                win_idx_c = IDX_W'((int'(last_q) + 1 + k) % int'(NUM_REQ));
            end
        end
`else
        // Lowest index wins: screen clear beats every other engine.
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (!win_vld_c && bus.req[k]) begin
                win_vld_c = 1'b1;
                win_idx_c = IDX_W'(k);
            end
        end
`endif
    end

    logic owner_req_c;
    logic owner_done_c;
    logic owner_plot_c;

    assign owner_req_c  = bus.req[owner_q];
    assign owner_done_c = bus.done[owner_q];
    assign owner_plot_c = bus.plot_in[owner_q];

    // Ownership FSM with registered grant and registered VGA write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            gnt_q         <= '0;
            busy_q        <= 1'b0;
            vga_x_q       <= '0;
            vga_y_q       <= '0;
            vga_colour_q  <= '0;
            vga_plot_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            wd_q          <= '0;
`ifdef PLOT_ARB_ROUND_ROBIN_EN
            last_q        <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    vga_plot_q <= 1'b0;
                    if (win_vld_c) begin
                        state_q <= ST_OWN;
                        owner_q <= win_idx_c;
                        gnt_q   <= NUM_REQ'(1) << win_idx_c;
                        busy_q  <= 1'b1;
                        wd_q    <= '0;
`ifdef PLOT_ARB_ROUND_ROBIN_EN
                        last_q  <= win_idx_c;
`endif
                    end
                end
                ST_OWN: begin
                    // Forward the owner's pixel, including on the final owned cycle.
                    vga_x_q      <= x_arr[owner_q];
                    vga_y_q      <= y_arr[owner_q];
                    vga_colour_q <= colour_arr[owner_q];
                    vga_plot_q   <= owner_plot_c;
                    if (owner_done_c || !owner_req_c) begin
                        state_q <= ST_RELEASE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (wd_q == WD_MAX) begin
                        state_q       <= ST_RELEASE;
                        gnt_q         <= '0;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // Dead cycle so the old owner observes gnt low before re-arbitration.
                    state_q    <= ST_IDLE;
                    vga_plot_q <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    gnt_q      <= '0;
                    busy_q     <= 1'b0;
                    vga_plot_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.busy        = busy_q;
    assign bus.vga_x       = vga_x_q;
    assign bus.vga_y       = vga_y_q;
    assign bus.vga_colour  = vga_colour_q;
    assign bus.vga_plot    = vga_plot_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Purpose : self-checking bench for vga_plot_arbiter; a vector table covers the
//           single-owner, foreign-strobe and release paths, hand-written sequences
//           cover contention, round-robin/fixed priority, watchdog and async reset.
module tb_vga_plot_arbiter;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned X_W     = 8;
    localparam int unsigned Y_W     = 7;
    localparam int unsigned COLOR_W = 3;
    localparam int unsigned TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset;

    vga_plot_arbiter_if #(
        .NUM_REQ(NUM_REQ), .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)
    ) bus ();

    vga_plot_arbiter #(
        .NUM_REQ(NUM_REQ), .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] plot;
        logic [7:0] x1;
        logic [7:0] x2;
        logic [6:0] y1;
        logic [2:0] c1;
        logic [3:0] e_gnt;
        logic       e_busy;
        logic       e_plot;
        logic [7:0] e_x;
        logic [6:0] e_y;
        logic [2:0] e_c;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.req       = '0;
        bus.done      = '0;
        bus.plot_in   = '0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.colour_in = '0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;

        //            req      done     plot     x1     x2      y1    c1    | gnt     busy  plot  vx      vy    vc
        tbl[0] = '{4'b0010, 4'b0000, 4'b0010, 8'd5, 8'd0,  7'd9, 3'd6, 4'b0010, 1'b1, 1'b0, 8'd0,  7'd0, 3'd0};
        tbl[1] = '{4'b0010, 4'b0000, 4'b0010, 8'd5, 8'd0,  7'd9, 3'd6, 4'b0010, 1'b1, 1'b1, 8'd5,  7'd9, 3'd6};
        tbl[2] = '{4'b0010, 4'b0000, 4'b0100, 8'd6, 8'd77, 7'd9, 3'd6, 4'b0010, 1'b1, 1'b0, 8'd6,  7'd9, 3'd6};
        tbl[3] = '{4'b0010, 4'b0000, 4'b0110, 8'd7, 8'd77, 7'd9, 3'd6, 4'b0010, 1'b1, 1'b1, 8'd7,  7'd9, 3'd6};
        tbl[4] = '{4'b0010, 4'b1000, 4'b0100, 8'd7, 8'd77, 7'd9, 3'd6, 4'b0010, 1'b1, 1'b0, 8'd7,  7'd9, 3'd6};
        tbl[5] = '{4'b0010, 4'b0010, 4'b0010, 8'd8, 8'd77, 7'd9, 3'd6, 4'b0000, 1'b0, 1'b1, 8'd8,  7'd9, 3'd6};
        tbl[6] = '{4'b0100, 4'b0000, 4'b0000, 8'd8, 8'd77, 7'd9, 3'd6, 4'b0000, 1'b0, 1'b0, 8'd8,  7'd9, 3'd6};
        tbl[7] = '{4'b0100, 4'b0000, 4'b0100, 8'd8, 8'd77, 7'd9, 3'd6, 4'b0100, 1'b1, 1'b0, 8'd8,  7'd9, 3'd6};
        tbl[8] = '{4'b0000, 4'b0000, 4'b0100, 8'd8, 8'd77, 7'd9, 3'd6, 4'b0000, 1'b0, 1'b1, 8'd77, 7'd0, 3'd0};
        tbl[9] = '{4'b0000, 4'b0000, 4'b0000, 8'd0, 8'd0,  7'd0, 3'd0, 4'b0000, 1'b0, 1'b0, 8'd77, 7'd0, 3'd0};

        tick();
        tick();
        check("rst_gnt",  32'(bus.gnt),         32'd0);
        check("rst_busy", 32'(bus.busy),        32'd0);
        check("rst_plot", 32'(bus.vga_plot),    32'd0);
        check("rst_x",    32'(bus.vga_x),       32'd0);
        check("rst_err",  32'(bus.timeout_err), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_gnt", 32'(bus.gnt), 32'd0);

        // Vector table: inputs applied, one edge, outputs compared.
        for (int i = 0; i < 10; i++) begin
            bus.req       = tbl[i].req;
            bus.done      = tbl[i].done;
            bus.plot_in   = tbl[i].plot;
            bus.x_in      = {8'd0, tbl[i].x2, tbl[i].x1, 8'd0};
            bus.y_in      = {7'd0, 7'd0, tbl[i].y1, 7'd0};
            bus.colour_in = {3'd0, 3'd0, tbl[i].c1, 3'd0};
            tick();
            check($sformatf("row%0d_gnt", i),  32'(bus.gnt),        32'(tbl[i].e_gnt));
            check($sformatf("row%0d_busy", i), 32'(bus.busy),       32'(tbl[i].e_busy));
            check($sformatf("row%0d_plot", i), 32'(bus.vga_plot),   32'(tbl[i].e_plot));
            check($sformatf("row%0d_x", i),    32'(bus.vga_x),      32'(tbl[i].e_x));
            check($sformatf("row%0d_y", i),    32'(bus.vga_y),      32'(tbl[i].e_y));
            check($sformatf("row%0d_col", i),  32'(bus.vga_colour), 32'(tbl[i].e_c));
        end
        clear_inputs();

`ifndef PLOT_ARB_ROUND_ROBIN_EN
        // Contention: clear beats colour line; next grant lands 3 cycles after done.
        bus.req = 4'b1001;
        tick();
        check("cont_first", 32'(bus.gnt), 32'b0001);
        bus.done = 4'b0001;
        bus.req  = 4'b1000;
        tick();
        check("cont_release", 32'(bus.gnt), 32'd0);
        bus.done = 4'b0000;
        tick();
        check("cont_idle", 32'(bus.gnt), 32'd0);
        tick();
        check("cont_second", 32'(bus.gnt), 32'b1000);
        bus.req = 4'b0000;
        tick();
        check("cont_drop_busy", 32'(bus.busy), 32'd0);
        tick();
`endif

        // Watchdog: owner 2 never releases.
        bus.req = 4'b0100;
        tick();
        check("wd_grant", 32'(bus.gnt), 32'b0100);
        for (int i = 1; i < int'(TIMEOUT); i++) begin
            tick();
            check($sformatf("wd_hold%0d", i), 32'(bus.gnt), 32'b0100);
        end
        check("wd_err_before", 32'(bus.timeout_err), 32'd0);
        tick();
        check("wd_gnt_drop", 32'(bus.gnt),         32'd0);
        check("wd_busy_drop", 32'(bus.busy),       32'd0);
        check("wd_err_set",  32'(bus.timeout_err), 32'd1);
        tick();
        check("wd_idle", 32'(bus.gnt), 32'd0);
        tick();
        check("wd_regrant", 32'(bus.gnt),        32'b0100);
        check("wd_err_sticky", 32'(bus.timeout_err), 32'd1);

        // Async reset mid-ownership.
        bus.plot_in = 4'b0100;
        bus.x_in    = {8'd0, 8'd33, 8'd0, 8'd0};
        tick();
        check("pre_rst_plot", 32'(bus.vga_plot), 32'd1);
        check("pre_rst_x",    32'(bus.vga_x),    32'd33);
        reset = 1'b1;
        #1;
        check("async_gnt",  32'(bus.gnt),         32'd0);
        check("async_plot", 32'(bus.vga_plot),    32'd0);
        check("async_busy", 32'(bus.busy),        32'd0);
        check("async_err",  32'(bus.timeout_err), 32'd0);
        clear_inputs();
        tick();
        reset = 1'b0;
        tick();

`ifdef PLOT_ARB_ROUND_ROBIN_EN
        // Round robin: 0 and 1 both held, each releases after 2 owned cycles.
        begin
            logic [3:0] rr_exp [3];
            rr_exp[0] = 4'b0001;
            rr_exp[1] = 4'b0010;
            rr_exp[2] = 4'b0001;
            bus.req = 4'b0011;
            for (int r = 0; r < 3; r++) begin
                tick();
                check($sformatf("rr_gnt%0d", r), 32'(bus.gnt), 32'(rr_exp[r]));
                tick();
                bus.done = rr_exp[r];
                tick();
                bus.done = 4'b0000;
                tick();
            end
            bus.req = 4'b0000;
        end
`else
        // Fixed priority: lower index wins even when held continuously.
        bus.req = 4'b0110;
        tick();
        check("fix_gnt_a", 32'(bus.gnt), 32'b0010);
        bus.done = 4'b0010;
        tick();
        bus.done = 4'b0000;
        tick();
        tick();
        check("fix_gnt_b", 32'(bus.gnt), 32'b0010);
        bus.req = 4'b0000;
`endif
        tick();
        tick();
        check("final_idle", 32'(bus.gnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
